// File: rtl/grid_pkg.sv
// Shared geometry, FSM encoding and address helpers
// for the double-buffered Life cell store.
package grid_pkg;
  localparam int GRID_W = 80;
  localparam int GRID_H = 60;
  localparam int CELLS  = GRID_W * GRID_H;
  localparam int ADDR_W = 13;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    SWAP
  } state_t;

  function automatic logic [ADDR_W-1:0] xy_to_addr(
    input logic [6:0] x,
    input logic [5:0] y
  );
    return ADDR_W'(y) * ADDR_W'(GRID_W) + ADDR_W'(x);
  endfunction

  function automatic logic xy_in_range(
    input logic [6:0] x,
    input logic [5:0] y
  );
    return (x < 7'(GRID_W)) && (y < 6'(GRID_H));
  endfunction
endpackage

// File: rtl/cell_grid_store_bank.sv
// One 4800x1 cell bank: async read, registered read,
// single write port.
module grid_bank
  import grid_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra,
  output logic              rd,
  input  logic [ADDR_W-1:0] sa,
  output logic              sd,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic              wd
);
  logic mem [CELLS];
  logic sd_d;
  logic sd_q;

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_comb begin
    rd   = mem[ra];
    sd_d = mem[sa];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sd_q <= 1'b0;
    else     sd_q <= sd_d;
  end

  assign sd = sd_q;
endmodule

// File: rtl/cell_grid_store.sv
// Double-buffered Life grid: engine/display/edit ports,
// clear sweep and generation swap handshake.
module cell_grid_store
  import grid_pkg::*;
#(
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       read_x,
  input  logic [5:0]       read_y,
  output logic             cell_state,
  input  logic [6:0]       write_x,
  input  logic [5:0]       write_y,
  input  logic             write_value,
  input  logic             write_enable,
  input  logic [6:0]       disp_x,
  input  logic [5:0]       disp_y,
  output logic             disp_cell,
  input  logic             edit_en,
  input  logic [6:0]       edit_x,
  input  logic [5:0]       edit_y,
  input  logic             edit_value,
  input  logic             swap_req,
  output logic             swap_ack,
  input  logic             clear_req,
  output logic             clear_busy,
  output logic [GEN_W-1:0] gen_count
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              cur_bank_q, cur_bank_d;
  logic [GEN_W-1:0]  gen_q, gen_d;
  logic              ack_q, ack_d;
  logic              disp_ok_q, disp_ok_d;
  logic              disp_bank_q, disp_bank_d;

  logic              rd_ok, wr_ok, ed_ok, dp_ok;
  logic [ADDR_W-1:0] rd_addr, wr_addr, ed_addr, dp_addr;
  logic [1:0]        we;
  logic [ADDR_W-1:0] wa;
  logic              wd;
  logic              rd0, rd1, sd0, sd1;

  // Out-of-range coordinates map to address 0 but are masked
  always_comb begin
    rd_ok   = xy_in_range(read_x, read_y);
    wr_ok   = xy_in_range(write_x, write_y);
    ed_ok   = xy_in_range(edit_x, edit_y);
    dp_ok   = xy_in_range(disp_x, disp_y);
    rd_addr = rd_ok ? xy_to_addr(read_x, read_y) : '0;
    wr_addr = wr_ok ? xy_to_addr(write_x, write_y) : '0;
    ed_addr = ed_ok ? xy_to_addr(edit_x, edit_y) : '0;
    dp_addr = dp_ok ? xy_to_addr(disp_x, disp_y) : '0;
  end

  // Edit shares the next bank's single port and takes priority
  always_comb begin
    we = 2'b00;
    wa = '0;
    wd = 1'b0;
    if (state_q == CLEAR) begin
      we = 2'b11;
      wa = clr_addr_q;
    end else if (edit_en && ed_ok) begin
      we = 2'b11;
      wa = ed_addr;
      wd = edit_value;
    end else if (write_enable && wr_ok) begin
      we = cur_bank_q ? 2'b01 : 2'b10;
      wa = wr_addr;
      wd = write_value;
    end
  end

  grid_bank u_bank0 (
    .clk(clk), .rst(rst),
    .ra(rd_addr), .rd(rd0),
    .sa(dp_addr), .sd(sd0),
    .we(we[0]), .wa(wa), .wd(wd)
  );

  grid_bank u_bank1 (
    .clk(clk), .rst(rst),
    .ra(rd_addr), .rd(rd1),
    .sa(dp_addr), .sd(sd1),
    .we(we[1]), .wa(wa), .wd(wd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_addr_q  <= '0;
      cur_bank_q  <= 1'b0;
      gen_q       <= '0;
      ack_q       <= 1'b0;
      disp_ok_q   <= 1'b0;
      disp_bank_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      cur_bank_q  <= cur_bank_d;
      gen_q       <= gen_d;
      ack_q       <= ack_d;
      disp_ok_q   <= disp_ok_d;
      disp_bank_q <= disp_bank_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    cur_bank_d  = cur_bank_q;
    gen_d       = gen_q;
    ack_d       = 1'b0;
    disp_ok_d   = dp_ok;
    disp_bank_d = cur_bank_q;
    unique case (state_q)
      CLEAR: begin
        if (clr_addr_q == ADDR_W'(CELLS - 1)) begin
          state_d    = IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
          gen_d      = '0;
        end else if (swap_req) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        state_d    = IDLE;
        cur_bank_d = ~cur_bank_q;
        gen_d      = gen_q + GEN_W'(1);
        ack_d      = 1'b1;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    clear_busy = (state_q == CLEAR);
    swap_ack   = ack_q;
    gen_count  = gen_q;
    cell_state = rd_ok & (cur_bank_q ? rd1 : rd0);
    disp_cell  = disp_ok_q & (disp_bank_q ? sd1 : sd0);
  end
endmodule

// File: tb/tb_cell_grid_store.sv
// Directed bench for cell_grid_store: clear, edit, engine
// writes, swap handshake, range masking and counter wrap.
module tb_cell_grid_store;
  localparam int GW = 8;

  logic          clk;
  logic          rst;
  logic [6:0]    read_x;
  logic [5:0]    read_y;
  logic          cell_state;
  logic [6:0]    write_x;
  logic [5:0]    write_y;
  logic          write_value;
  logic          write_enable;
  logic [6:0]    disp_x;
  logic [5:0]    disp_y;
  logic          disp_cell;
  logic          edit_en;
  logic [6:0]    edit_x;
  logic [5:0]    edit_y;
  logic          edit_value;
  logic          swap_req;
  logic          swap_ack;
  logic          clear_req;
  logic          clear_busy;
  logic [GW-1:0] gen_count;

  int n_checks;
  int n_fail;
  int exp_gen;

  cell_grid_store #(.GEN_W(GW)) dut (
    .clk(clk), .rst(rst),
    .read_x(read_x), .read_y(read_y),
    .cell_state(cell_state),
    .write_x(write_x), .write_y(write_y),
    .write_value(write_value),
    .write_enable(write_enable),
    .disp_x(disp_x), .disp_y(disp_y),
    .disp_cell(disp_cell),
    .edit_en(edit_en),
    .edit_x(edit_x), .edit_y(edit_y),
    .edit_value(edit_value),
    .swap_req(swap_req), .swap_ack(swap_ack),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .gen_count(gen_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic zero_inputs();
    read_x = 0; read_y = 0;
    write_x = 0; write_y = 0;
    write_value = 0; write_enable = 0;
    disp_x = 0; disp_y = 0;
    edit_en = 0; edit_x = 0; edit_y = 0;
    edit_value = 0;
    swap_req = 0; clear_req = 0;
  endtask

  task automatic rd(input int x, input int y);
    read_x = 7'(x);
    read_y = 6'(y);
    #1;
  endtask

  task automatic eng_wr(input int x, input int y,
                        input logic v);
    write_x = 7'(x); write_y = 6'(y);
    write_value = v; write_enable = 1;
    cycle(1);
    write_enable = 0;
  endtask

  task automatic edit_wr(input int x, input int y,
                         input logic v);
    edit_x = 7'(x); edit_y = 6'(y);
    edit_value = v; edit_en = 1;
    cycle(1);
    edit_en = 0;
  endtask

  task automatic do_swap(output bit got);
    swap_req = 1;
    cycle(1);
    swap_req = 0;
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      cycle(1);
      if (swap_ack) got = 1;
    end
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (clear_busy && n < 6000) begin
      cycle(1);
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    int bad;
    rst = 1;
    #12;
    n_checks++;
    if (clear_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_busy got=%b exp=1", clear_busy);
    end
    n_checks++;
    if (swap_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ack got=%b exp=0", swap_ack);
    end
    n_checks++;
    if (gen_count !== '0) begin
      n_fail++;
      $display("FAIL reset_gen got=%0d exp=0", gen_count);
    end
    n_checks++;
    if (disp_cell !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_disp got=%b exp=0", disp_cell);
    end
    @(posedge clk);
    #1;
    rst = 0;
    wait_clear(n);
    n_checks++;
    if (n != 4800) begin
      n_fail++;
      $display("FAIL reset_clear_len got=%0d exp=4800", n);
    end
    bad = 0;
    for (int y = 0; y < 60; y++)
      for (int x = 0; x < 80; x++) begin
        rd(x, y);
        if (cell_state !== 1'b0) bad++;
      end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_sweep nonzero=%0d exp=0", bad);
    end
    n_checks++;
    if (gen_count !== '0) begin
      n_fail++;
      $display("FAIL clear_gen got=%0d exp=0", gen_count);
    end
    exp_gen = 0;
  endtask

  task automatic test_edit();
    bit got;
    edit_wr(10, 5, 1);
    rd(10, 5);
    n_checks++;
    if (cell_state !== 1'b1) begin
      n_fail++;
      $display("FAIL edit_read got=%b exp=1", cell_state);
    end
    disp_x = 10; disp_y = 5;
    cycle(1);
    n_checks++;
    if (disp_cell !== 1'b1) begin
      n_fail++;
      $display("FAIL edit_disp got=%b exp=1", disp_cell);
    end
    do_swap(got);
    exp_gen++;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL edit_swap_ack got=0 exp=1");
    end
    rd(10, 5);
    n_checks++;
    if (cell_state !== 1'b1) begin
      n_fail++;
      $display("FAIL edit_after_swap got=%b exp=1",
               cell_state);
    end
    n_checks++;
    if (gen_count !== GW'(exp_gen)) begin
      n_fail++;
      $display("FAIL edit_gen got=%0d exp=%0d",
               gen_count, exp_gen);
    end
  endtask

  task automatic test_engine_write();
    eng_wr(0, 0, 1);
    rd(0, 0);
    n_checks++;
    if (cell_state !== 1'b0) begin
      n_fail++;
      $display("FAIL eng_before_swap got=%b exp=0",
               cell_state);
    end
    swap_req = 1;
    cycle(1);
    write_x = 20; write_y = 20;
    write_value = 1; write_enable = 1;
    rd(0, 0);
    n_checks++;
    if (cell_state !== 1'b0 || swap_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL eng_swap_state cell=%b ack=%b exp=0,0",
               cell_state, swap_ack);
    end
    cycle(1);
    write_enable = 0;
    swap_req = 0;
    exp_gen++;
    rd(0, 0);
    n_checks++;
    if (swap_ack !== 1'b1 || cell_state !== 1'b1) begin
      n_fail++;
      $display("FAIL eng_ack_cycle ack=%b cell=%b exp=1,1",
               swap_ack, cell_state);
    end
    n_checks++;
    if (gen_count !== GW'(exp_gen)) begin
      n_fail++;
      $display("FAIL eng_gen got=%0d exp=%0d",
               gen_count, exp_gen);
    end
    rd(20, 20);
    n_checks++;
    if (cell_state !== 1'b1) begin
      n_fail++;
      $display("FAIL eng_swap_cycle_write got=%b exp=1",
               cell_state);
    end
    cycle(1);
    n_checks++;
    if (swap_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL eng_ack_pulse got=%b exp=0", swap_ack);
    end
    cycle(3);
    n_checks++;
    if (gen_count !== GW'(exp_gen)) begin
      n_fail++;
      $display("FAIL eng_swap_in_swap gen=%0d exp=%0d",
               gen_count, exp_gen);
    end
  endtask

  task automatic test_collision();
    bit got;
    write_x = 79; write_y = 59;
    write_value = 0; write_enable = 1;
    edit_x = 79; edit_y = 59;
    edit_value = 1; edit_en = 1;
    cycle(1);
    write_enable = 0;
    edit_en = 0;
    rd(79, 59);
    n_checks++;
    if (cell_state !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_current got=%b exp=1", cell_state);
    end
    eng_wr(80, 0, 1);
    eng_wr(0, 60, 1);
    edit_wr(80, 5, 1);
    edit_wr(127, 63, 1);
    do_swap(got);
    exp_gen++;
    rd(79, 59);
    n_checks++;
    if (cell_state !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_after_swap got=%b exp=1",
               cell_state);
    end
    rd(0, 1);
    n_checks++;
    if (cell_state !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_wr_alias01 got=%b exp=0", cell_state);
    end
    rd(0, 6);
    n_checks++;
    if (cell_state !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_edit_alias06 got=%b exp=0",
               cell_state);
    end
    rd(0, 60);
    n_checks++;
    if (cell_state !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_read_0_60 got=%b exp=0", cell_state);
    end
    edit_wr(0, 1, 1);
    rd(80, 0);
    n_checks++;
    if (cell_state !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_read_80_0 got=%b exp=0", cell_state);
    end
    rd(0, 1);
    n_checks++;
    if (cell_state !== 1'b1) begin
      n_fail++;
      $display("FAIL edit_0_1 got=%b exp=1", cell_state);
    end
    disp_x = 80; disp_y = 0;
    cycle(1);
    n_checks++;
    if (disp_cell !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_disp_80_0 got=%b exp=0", disp_cell);
    end
    disp_x = 0; disp_y = 1;
    cycle(1);
    n_checks++;
    if (disp_cell !== 1'b1) begin
      n_fail++;
      $display("FAIL disp_0_1 got=%b exp=1", disp_cell);
    end
  endtask

  task automatic test_clear();
    int n;
    bit ack_seen;
    bit got;
    clear_req = 1;
    cycle(1);
    clear_req = 0;
    n_checks++;
    if (clear_busy !== 1'b1 || gen_count !== '0) begin
      n_fail++;
      $display("FAIL clr_enter busy=%b gen=%0d exp=1,0",
               clear_busy, gen_count);
    end
    exp_gen = 0;
    n = 0;
    ack_seen = 0;
    while (clear_busy && n < 6000) begin
      swap_req  = (n == 100);
      clear_req = (n == 200);
      edit_x = 3; edit_y = 3; edit_value = 1;
      edit_en = (n == 4000);
      write_x = 4; write_y = 4; write_value = 1;
      write_enable = (n == 4000);
      cycle(1);
      swap_req = 0; clear_req = 0;
      edit_en = 0; write_enable = 0;
      if (swap_ack) ack_seen = 1;
      n++;
    end
    n_checks++;
    if (n != 4800) begin
      n_fail++;
      $display("FAIL clr_len got=%0d exp=4800", n);
    end
    n_checks++;
    if (ack_seen) begin
      n_fail++;
      $display("FAIL clr_swap_dropped ack=1 exp=0");
    end
    rd(3, 3);
    n_checks++;
    if (cell_state !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_edit_dropped got=%b exp=0",
               cell_state);
    end
    rd(79, 59);
    n_checks++;
    if (cell_state !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_wiped got=%b exp=0", cell_state);
    end
    eng_wr(4, 4, 0);
    do_swap(got);
    rd(4, 4);
    n_checks++;
    if (cell_state !== 1'b0 || gen_count !== GW'(1)) begin
      n_fail++;
      $display("FAIL clr_eng_dropped cell=%b gen=%0d exp=0,1",
               cell_state, gen_count);
    end
    clear_req = 1;
    swap_req = 1;
    cycle(1);
    clear_req = 0;
    swap_req = 0;
    ack_seen = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1);
      if (swap_ack) ack_seen = 1;
    end
    n_checks++;
    if (clear_busy !== 1'b1 || ack_seen ||
        gen_count !== '0) begin
      n_fail++;
      $display("FAIL clr_vs_swap busy=%b ack=%b gen=%0d exp=1,0,0",
               clear_busy, ack_seen, gen_count);
    end
    cycle(1996);
    rst = 1;
    #2;
    n_checks++;
    if (clear_busy !== 1'b1 || swap_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst busy=%b ack=%b exp=1,0",
               clear_busy, swap_ack);
    end
    rst = 0;
    wait_clear(n);
    n_checks++;
    if (n != 4800) begin
      n_fail++;
      $display("FAIL mid_rst_len got=%0d exp=4800", n);
    end
    exp_gen = 0;
  endtask

  task automatic test_wrap_disp();
    logic exp_val;
    eng_wr(5, 5, 1);
    disp_x = 5; disp_y = 5;
    read_x = 5; read_y = 5;
    cycle(1);
    exp_val = 0;
    n_checks++;
    if (disp_cell !== 1'b0 || cell_state !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_start disp=%b cell=%b exp=0,0",
               disp_cell, cell_state);
    end
    for (int i = 0; i < (1 << GW); i++) begin
      swap_req = 1;
      cycle(1);
      swap_req = 0;
      cycle(1);
      exp_val = ~exp_val;
      exp_gen = (exp_gen + 1) % (1 << GW);
      n_checks++;
      if (swap_ack !== 1'b1 || cell_state !== exp_val ||
          disp_cell !== ~exp_val ||
          gen_count !== GW'(exp_gen)) begin
        n_fail++;
        $display("FAIL wrap_ack_cycle i=%0d ack=%b cell=%b disp=%b gen=%0d exp=1,%b,%b,%0d",
                 i, swap_ack, cell_state, disp_cell,
                 gen_count, exp_val, ~exp_val, exp_gen);
      end
      cycle(1);
      n_checks++;
      if (disp_cell !== exp_val) begin
        n_fail++;
        $display("FAIL wrap_disp_follow i=%0d got=%b exp=%b",
                 i, disp_cell, exp_val);
      end
    end
    n_checks++;
    if (gen_count !== '0) begin
      n_fail++;
      $display("FAIL wrap_gen got=%0d exp=0", gen_count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_gen = 0;
    zero_inputs();
    test_reset();
    test_edit();
    test_engine_write();
    test_collision();
    test_clear();
    test_wrap_disp();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
